// File: rtl/avalon_pio_master.sv
// Avalon-MM single-transfer initiator: turns a valid/ready command stream into one
// bus read or write at a time and returns a one-cycle response with read data and
// a timeout error flag.
module avalon_pio_master #(
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned READ_WAIT = 0,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] address,
  output logic              chipselect,
  output logic              write_n,
  output logic              read_n,
  output logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] readdata,
  input  logic              waitrequest
);

  localparam int unsigned     CntW       = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax     = CntW'(TIMEOUT);
  localparam logic [CntW-1:0] CntLast    = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] CntRdWait  = CntW'(READ_WAIT);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                is_write_q, is_write_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                chipselect_q, chipselect_d;
  logic                write_n_q, write_n_d;
  logic                read_n_q, read_n_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [DATA_W-1:0]   writedata_q, writedata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_error_q, rsp_error_d;
  logic                rd_wait_met;
  logic                bus_done;

  // With no read wait the comparison would be constant, so it is elided.
  if (READ_WAIT == 0) begin : g_no_rd_wait
    assign rd_wait_met = 1'b1;
  end else begin : g_rd_wait
    assign rd_wait_met = (cnt_q >= CntRdWait);
  end

  // Next-state and next-output logic for the IDLE -> BUS -> RESP sequence.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    is_write_d   = is_write_q;
    cmd_ready_d  = 1'b0;
    chipselect_d = chipselect_q;
    write_n_d    = write_n_q;
    read_n_d     = read_n_q;
    address_d    = address_q;
    writedata_d  = writedata_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_error_d  = rsp_error_q;
    bus_done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          state_d      = StBus;
          cmd_ready_d  = 1'b0;
          cnt_d        = '0;
          is_write_d   = cmd_write;
          chipselect_d = 1'b1;
          write_n_d    = ~cmd_write;
          read_n_d     = cmd_write;
          address_d    = cmd_address;
          writedata_d  = cmd_write ? cmd_wdata : '0;
        end
      end
      StBus: begin
        if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
        // Completion takes priority over a timeout in the same cycle.
        if (!waitrequest && (is_write_q || rd_wait_met)) begin
          bus_done    = 1'b1;
          rsp_rdata_d = is_write_q ? '0 : readdata;
          rsp_error_d = 1'b0;
        end else if (cnt_q == CntLast) begin
          bus_done    = 1'b1;
          rsp_rdata_d = '0;
          rsp_error_d = 1'b1;
        end
        if (bus_done) begin
          state_d      = StResp;
          rsp_valid_d  = 1'b1;
          chipselect_d = 1'b0;
          write_n_d    = 1'b1;
          read_n_d     = 1'b1;
        end
      end
      StResp: begin
        state_d     = StIdle;
        cmd_ready_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      is_write_q   <= 1'b0;
      cmd_ready_q  <= 1'b0;
      chipselect_q <= 1'b0;
      write_n_q    <= 1'b1;
      read_n_q     <= 1'b1;
      address_q    <= '0;
      writedata_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_write_q   <= is_write_d;
      cmd_ready_q  <= cmd_ready_d;
      chipselect_q <= chipselect_d;
      write_n_q    <= write_n_d;
      read_n_q     <= read_n_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_error_q  <= rsp_error_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign chipselect = chipselect_q;
  assign write_n    = write_n_q;
  assign read_n     = read_n_q;
  assign address    = address_q;
  assign writedata  = writedata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_error  = rsp_error_q;

endmodule

// File: tb/tb_avalon_pio_master.sv
// Scoreboard bench for avalon_pio_master with a PIO slave (data/set/clear) attached.
module tb_avalon_pio_master;
  localparam int unsigned AW = 3;
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 2;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_address = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          waitrequest = 1'b0;
  logic          cmd_ready, rsp_valid, rsp_error, chipselect, write_n, read_n;
  logic [DW-1:0] rsp_rdata, writedata, readdata;
  logic [AW-1:0] address;

  always #5 clk = ~clk;

  avalon_pio_master #(
    .ADDR_W(AW), .DATA_W(DW), .READ_WAIT(RW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .address(address), .chipselect(chipselect), .write_n(write_n), .read_n(read_n),
    .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest)
  );

  // PIO slave: data register at 0, set alias at 4, clear alias at 5.
  logic [DW-1:0] slave_reg = '0;
  always @(posedge clk) begin
    if (chipselect && !write_n && !waitrequest) begin
      case (address)
        3'd0:    slave_reg <= writedata;
        3'd4:    slave_reg <= slave_reg | writedata;
        3'd5:    slave_reg <= slave_reg & ~writedata;
        default: ;
      endcase
    end
  end
  assign readdata = (address == 3'd0) ? slave_reg : (32'hA5A5_0000 | {29'd0, address});

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        w;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          strobes;
    int          rsp_cyc;
    int          wr_acc;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model_reg = '0;
  int            stall_k = 0;

  // Issue one command; k = number of leading strobe cycles with waitrequest high.
  task automatic issue(input logic w, input logic [2:0] a, input logic [31:0] d,
                       input int k, input bit keep);
    exp_t e;
    int   n = 0;
    int   c;
    while (!cmd_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    c = w ? k : ((k > int'(RW)) ? k : int'(RW));
    e.w       = w;
    e.addr    = a;
    e.wdata   = w ? d : 32'd0;
    e.err     = (c >= int'(TO));
    e.strobes = e.err ? int'(TO) : c + 1;
    e.rdata   = (w || e.err) ? 32'd0 : ((a == 3'd0) ? model_reg : (32'hA5A5_0000 | {29'd0, a}));
    e.wr_acc  = (w && !e.err) ? 1 : 0;
    e.rsp_cyc = cyc + 1 + e.strobes;
    if (keep && w && !e.err) begin
      if (a == 3'd0) model_reg = d;
      else if (a == 3'd4) model_reg = model_reg | d;
      else if (a == 3'd5) model_reg = model_reg & ~d;
    end
    if (keep) exp_q.push_back(e);
    stall_k     = k;
    cmd_write   = w;
    cmd_address = a;
    cmd_wdata   = d;
    cmd_valid   = 1'b1;
    @(negedge clk);
    cmd_valid   = 1'b0;
    cmd_write   = 1'($urandom);
    cmd_address = 3'($urandom);
    cmd_wdata   = $urandom;
  endtask

  // Monitor: drives waitrequest per strobe cycle, tracks bus activity, scores responses.
  initial begin
    int   bus_idx = 0;
    int   strobes = 0;
    int   wr_acc = 0;
    bit   bus_ok = 1'b1;
    int   last_rsp = -10;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        strobes  = 0;
        wr_acc   = 0;
        bus_ok   = 1'b1;
        last_rsp = -10;
      end
      if (chipselect) begin
        waitrequest = (bus_idx < stall_k);
        bus_idx++;
      end else begin
        waitrequest = 1'($urandom_range(0, 1));
        bus_idx = 0;
      end
      if (chipselect) begin
        strobes++;
        if (!write_n && !waitrequest) wr_acc++;
        if (cmd_ready) bus_ok = 1'b0;
        if (exp_q.size() > 0) begin
          if (address !== exp_q[0].addr || writedata !== exp_q[0].wdata ||
              write_n !== !exp_q[0].w || read_n !== exp_q[0].w) bus_ok = 1'b0;
        end
      end
      if (rsp_valid) begin
        if (cmd_ready || chipselect) bus_ok = 1'b0;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d expected no response", cyc);
        end else begin
          e = exp_q.pop_front();
          check("rsp_error", 32'(rsp_error), 32'(e.err));
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_cycle", 32'(cyc), 32'(e.rsp_cyc));
          check("strobe_cycles", 32'(strobes), 32'(e.strobes));
          check("write_accepts", 32'(wr_acc), 32'(e.wr_acc));
          check("bus_stable", 32'(bus_ok), 32'd1);
        end
        strobes  = 0;
        wr_acc   = 0;
        bus_ok   = 1'b1;
        last_rsp = cyc;
      end else if (cyc == last_rsp + 1 && !reset) begin
        check("ready_after_rsp", 32'(cmd_ready), 32'd1);
      end
    end
  end

  initial begin
    logic        w;
    logic [2:0]  a;
    int          k;
    int          n;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_chipselect", 32'(chipselect), 32'd0);
    check("rst_write_n", 32'(write_n), 32'd1);
    check("rst_read_n", 32'(read_n), 32'd1);
    check("rst_address", 32'(address), 32'd0);
    check("rst_writedata", writedata, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_error", 32'(rsp_error), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(cmd_ready), 32'd1);

    issue(1'b1, 3'd0, 32'h0000_000A, 0, 1'b1);
    issue(1'b1, 3'd4, 32'h0000_0005, 0, 1'b1);
    issue(1'b1, 3'd5, 32'h0000_0001, 0, 1'b1);
    issue(1'b0, 3'd0, 32'h0, 0, 1'b1);
    issue(1'b1, 3'd0, 32'h0000_0003, 0, 1'b1);
    issue(1'b0, 3'd0, 32'h0, 0, 1'b1);
    issue(1'b1, 3'd0, 32'h0000_0077, 4, 1'b1);
    issue(1'b1, 3'd4, 32'h0000_0100, 20, 1'b1);
    issue(1'b0, 3'd0, 32'h0, 9, 1'b1);
    issue(1'b0, 3'd0, 32'h0, 7, 1'b1);
    issue(1'b1, 3'd5, 32'h0000_0001, 7, 1'b1);
    issue(1'b0, 3'd3, 32'h0, 1, 1'b1);

    for (int i = 0; i < 60; i++) begin
      w = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       a = 3'd0;
        1:       a = 3'd4;
        2:       a = 3'd5;
        default: a = 3'($urandom);
      endcase
      k = ($urandom_range(0, 9) == 0) ? int'($urandom_range(7, 12)) : int'($urandom_range(0, 5));
      issue(w, a, $urandom, k, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset in the second BUS cycle of a stalled read: the command is dropped.
    issue(1'b0, 3'd0, 32'h0, 20, 1'b0);
    @(negedge clk);
    check("cs_before_reset", 32'(chipselect), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_chipselect", 32'(chipselect), 32'd0);
    check("mid_rst_read_n", 32'(read_n), 32'd1);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_mid_rst", 32'(cmd_ready), 32'd1);
    issue(1'b1, 3'd0, 32'h0000_005A, 0, 1'b1);
    issue(1'b0, 3'd0, 32'h0, 0, 1'b1);

    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    check("slave_reg_final", slave_reg, model_reg);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/avalon_pio_master.md
Name: avalon_pio_master

Overview:
- Avalon-MM single-transfer initiator. Converts a local valid/ready command stream into one bus read or write at a time, using the same chipselect/address/write_n/writedata/readdata signalling as the team's PIO slaves.
- Lets a hardware state machine drive LED, switch and similar PIO registers without the Nios core. This includes the set (address 4) and clear (address 5) aliases.
- Returns a one-cycle response carrying read data and an error flag. The error flag is set when a transfer times out.

Parameters:
- ADDR_W, 3, width of bus address.
- DATA_W, 32, width of bus data.
- READ_WAIT, 0, minimum extra cycles the read strobe is held before readdata is sampled. 0 means readdata is sampled in the first strobe cycle.
- TIMEOUT, 255, maximum number of strobe cycles before a transfer is aborted. Must be greater than READ_WAIT.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- cmd_valid, in, 1, command present.
- cmd_ready, out, 1, command accepted when cmd_valid and cmd_ready are both high at a rising edge.
- cmd_write, in, 1, 1 = write, 0 = read.
- cmd_address, in, ADDR_W, target register address.
- cmd_wdata, in, DATA_W, write data.
- rsp_valid, out, 1, one-cycle response pulse. There is no backpressure.
- rsp_rdata, out, DATA_W, read data. 0 for writes and for errors.
- rsp_error, out, 1, transfer timed out.
- address, out, ADDR_W, bus address.
- chipselect, out, 1, bus select.
- write_n, out, 1, active-low write strobe.
- read_n, out, 1, active-low read strobe.
- writedata, out, DATA_W, bus write data.
- readdata, in, DATA_W, bus read data.
- waitrequest, in, 1, slave stall. Tie to 0 for zero-wait slaves.

Behaviour:
- Interface: one clock domain, clk. Synchronous active-high reset. All outputs are registered.
- Reset values:
  - cmd_ready = 0 during reset, 1 in the first cycle after reset.
  - chipselect = 0, write_n = 1, read_n = 1.
  - address = 0, writedata = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_error = 0.
  - State = IDLE, counter = 0.
- Reset mid-transfer: strobes drop on the next edge. No response is issued and the command is lost.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready = 1.
  - On accept: latch cmd_address, cmd_wdata and cmd_write, clear the counter, go to BUS.
  - The bus outputs take their new values from the next cycle.
- BUS:
  - chipselect = 1. write_n = ~cmd_write and read_n = cmd_write, so exactly one strobe is low.
  - address and writedata are held stable for the whole state. writedata is 0 for reads.
  - cmd_ready = 0.
  - The counter increments every BUS cycle and saturates at TIMEOUT.
- Write completion: the first BUS cycle in which waitrequest = 0.
- Read completion: the first BUS cycle in which waitrequest = 0 and counter >= READ_WAIT. readdata is sampled into rsp_rdata at that edge.
- On completion: strobes deassert and chipselect = 0 on the next edge, and the FSM goes to RESP.
- Timeout:
  - Condition: counter == TIMEOUT - 1 and no completion in that cycle, i.e. after TIMEOUT strobe cycles.
  - Action: go to RESP with rsp_error = 1 and rsp_rdata = 0.
  - If completion and timeout occur in the same cycle, completion wins.
- RESP:
  - rsp_valid = 1 for exactly one cycle, then return to IDLE.
  - rsp_rdata and rsp_error hold their values until the next response.
  - cmd_ready = 0.
- Latency with no wait states: accept at edge N; strobe in cycle N+1; rsp_valid in cycle N+2; cmd_ready high again in cycle N+3. Maximum throughput is one command every 3 cycles.
- Single outstanding transfer; no pipelining. Command fields are ignored outside the accepting edge.
- A write strobe (chipselect=1, write_n=0, waitrequest=0) is asserted for exactly one cycle per write command, so set/clear aliases are never applied twice.

Test Plan:
- Write, address 0, data 0x0000000A, waitrequest = 0, PIO slave model attached → exactly one strobe cycle with address = 0 and writedata = 0xA; rsp_valid one cycle later with rsp_error = 0 and rsp_rdata = 0; slave register = 0xA; cmd_ready returns 3 cycles after accept.
- Back-to-back commands: write 0x5 to address 4, then 0x1 to address 5, then read address 0 → slave register goes 0xA → 0xF → 0xE; the read response has rsp_rdata = 0x0000000E; each set/clear strobe lasts exactly 1 cycle.
- READ_WAIT = 2, read address 0 with the slave holding 0x3 → read_n low for 3 cycles; rsp_rdata = 0x3; rsp_valid asserted in cycle N+4.
- waitrequest held high for 4 strobe cycles during a write → strobe held for 5 cycles with address and writedata stable; exactly one register update; normal response.
- TIMEOUT = 8, waitrequest stuck high → strobe lasts exactly 8 cycles; rsp_valid with rsp_error = 1 and rsp_rdata = 0; the next command is accepted normally.
- Reset asserted in the second BUS cycle of a stalled read → chipselect = 0, read_n = 1 and cmd_ready = 0 after the edge; no rsp_valid; cmd_ready = 1 in the first cycle after reset deasserts.
